move_collector: RTL and testbench



---
 rtl/move_collector_pkg.sv | 16 +
 rtl/move_collector_rr_arbiter.sv | 20 ++
 rtl/move_collector.sv | 85 ++++++++
 tb/tb_move_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/move_collector_pkg.sv
// move_collector_pkg: shared chess move-word fields, board sizes and collector state encodings
package move_collector_pkg;
  localparam int NCOL = 8;
  localparam int W = 160;
  localparam int SQ_W = 6;
  localparam int MV_INVALID = 0;
  localparam int MV_PROMOTE = 1;
  localparam int MV_PAWN = 2;
  localparam int MV_PAWN2 = 3;
  localparam int MV_EP = 4;
  localparam int MV_CASTLE = 5;
  localparam int MV_CAPTURE = 6;
  localparam int MV_FROM_LSB = 7;
  localparam int MV_TO_LSB = MV_FROM_LSB + SQ_W;
  typedef enum logic [2:0] {SCAN, READ, CAPT, HOLD, DONE} state_t;
endpackage

// File: rtl/move_collector_rr_arbiter.sv
// rr_arbiter: picks the first requesting column at or above the pointer, wrapping modulo NCOL
module rr_arbiter #(
  parameter int NCOL = 8,
  parameter int IDX_W = 3
) (
  input  logic [NCOL-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NCOL-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  // scan offsets high to low so the smallest offset from the pointer wins
  always_comb begin
    o_idx = '0;
    for (int i = NCOL - 1; i >= 0; i--)
      o_idx = i_req[(int'(i_ptr) + i) % NCOL] ? IDX_W'((int'(i_ptr) + i) % NCOL) : o_idx;
  end
  assign o_any = |i_req;
  assign o_gnt = o_any ? {{(NCOL-1){1'b0}}, 1'b1} << o_idx : '0;
endmodule

// File: rtl/move_collector.sv
// move_collector: round-robin drain of column move FIFOs onto one valid/ready stream
module move_collector #(
  parameter int NCOL = move_collector_pkg::NCOL,
  parameter int W = move_collector_pkg::W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCOL-1:0]   col_done,
  input  logic [NCOL-1:0]   col_empty,
  input  logic [NCOL*W-1:0] col_data,
  output logic [NCOL-1:0]   col_rden,
  output logic [W-1:0]      mv_data,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [CNT_W-1:0]  mv_count,
  output logic              all_done
);
  import move_collector_pkg::*;
  localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;
  state_t           r_state;
  logic [IDX_W-1:0] r_ptr, r_sel, w_idx;
  logic [NCOL-1:0]  r_rden, w_gnt;
  logic [W-1:0]     r_data;
  logic             r_valid, r_done, w_any;
  logic [CNT_W-1:0] r_cnt;
  rr_arbiter #(.NCOL(NCOL), .IDX_W(IDX_W)) u_arb (
    .i_req(~col_empty),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  // collector FSM: one read per word, one settle cycle after each pop, then hold until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_rden  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        SCAN: begin
          if (w_any) begin
            r_rden  <= w_gnt;
            r_sel   <= w_idx;
            r_state <= READ;
          end else if (&col_done && &col_empty) begin
            r_state <= DONE;
          end
        end
        READ: begin
          r_rden  <= '0;
          r_state <= CAPT;
        end
        CAPT: begin
          r_data  <= col_data[int'(r_sel)*W +: W];
          r_valid <= 1'b1;
          r_ptr   <= (int'(r_sel) == NCOL - 1) ? '0 : r_sel + 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (mv_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= &r_cnt ? r_cnt : r_cnt + 1'b1;
            r_state <= SCAN;
          end
        end
        default: r_done <= 1'b1;
      endcase
    end
  end
  assign col_rden = r_rden;
  assign mv_data  = r_data;
  assign mv_valid = r_valid;
  assign mv_count = r_cnt;
  assign all_done = r_done;
  a_rden_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(col_rden));
  a_data_stable: assert property (@(posedge clk) disable iff (reset) mv_valid && !mv_ready |=> $stable(mv_data));
  a_no_empty_rd: assert property (@(posedge clk) disable iff (reset) (r_state == SCAN) |-> !(|(w_gnt & col_empty)));
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: scoreboard bench with a FIFO model per column and a saturating-counter twin
module tb_move_collector;
  import move_collector_pkg::*;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCOL-1:0]   col_done = '0;
  logic [NCOL-1:0]   col_empty = '1;
  logic [NCOL*W-1:0] col_data = '0;
  logic [NCOL-1:0]   col_rden, s_rden;
  logic [W-1:0]      mv_data, s_data;
  logic              mv_valid, s_valid, mv_ready = 1'b0, all_done, s_done;
  logic [15:0]       mv_count;
  logic [3:0]        s_count;
  logic [NCOL-1:0]   ld_mask = '0;
  logic [W-1:0]      ld_word [NCOL];
  logic [W-1:0]      fq [NCOL][$];
  logic [W-1:0]      exp_word [$];
  int                exp_gnt [$];
  int                n_chk = 0, n_err = 0;

  move_collector u_dut (
    .clk(clk), .reset(reset), .col_done(col_done), .col_empty(col_empty), .col_data(col_data),
    .col_rden(col_rden), .mv_data(mv_data), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_count(mv_count), .all_done(all_done)
  );
  move_collector #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .col_done(col_done), .col_empty(col_empty), .col_data(col_data),
    .col_rden(s_rden), .mv_data(s_data), .mv_valid(s_valid), .mv_ready(mv_ready),
    .mv_count(s_count), .all_done(s_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // normal-mode column FIFOs: q appears the cycle after rdreq
  always @(posedge clk) begin
    logic [W-1:0] tmp;
    for (int k = 0; k < NCOL; k++) begin
      if (reset) fq[k].delete();
      else begin
        if (col_rden[k] && fq[k].size() > 0) begin
          tmp = fq[k].pop_front();
          col_data[k*W +: W] <= tmp;
        end
        if (ld_mask[k]) fq[k].push_back(ld_word[k]);
      end
      col_empty[k] <= (fq[k].size() == 0);
    end
  end

  // scoreboard: grants and accepted words checked against predicted order
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (!reset) begin
      if (col_rden != '0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", W'(col_rden), '0);
        else chk("gnt", W'(col_rden), W'(1) << exp_gnt.pop_front());
      end
      if (mv_valid && mv_ready) begin
        if (exp_word.size() == 0) chk("word_unexpected", W'(mv_valid), '0);
        else begin
          w = exp_word.pop_front();
          chk("word", mv_data, w);
          chk("sat_valid", W'(s_valid), W'(1));
          chk("sat_word", s_data, w);
        end
      end
    end
  end

  task automatic load(input int k, input logic [W-1:0] w);
    ld_mask[k] = 1'b1;
    ld_word[k] = w;
  endtask

  task automatic commit();
    @(posedge clk);
    #1 ld_mask = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    col_done = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (exp_word.size() + exp_gnt.size()) > 0; i++) @(negedge clk);
    chk("drain_left", W'(exp_word.size() + exp_gnt.size()), '0);
  endtask

  initial begin
    logic [W-1:0] wa, wb, wx, wy, wz;
    wa = {20{8'hA5}};
    wb = {20{8'h5A}};
    wx = {5{32'hDEAD_0001}};
    wy = {5{32'hBEEF_0002}};
    wz = {5{32'hCAFE_0003}};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // idle with nothing to do: no reads, nothing valid
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_rden", W'(col_rden), '0);
    end
    chk("rst_valid", W'(mv_valid), '0);
    chk("rst_done", W'(all_done), '0);
    chk("rst_count", W'(mv_count), '0);
    chk("rst_state", W'(u_dut.r_state), W'(SCAN));
    @(posedge clk);
    #1 col_done = '1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("done_2cyc", W'(all_done), W'(1));
    // single column, two words
    do_reset();
    chk("done_cleared", W'(all_done), '0);
    mv_ready = 1'b1;
    load(3, wa); exp_gnt.push_back(3); exp_word.push_back(wa); commit();
    load(3, wb); exp_gnt.push_back(3); exp_word.push_back(wb); commit();
    drain(50);
    @(negedge clk);
    chk("single_count", W'(mv_count), W'(2));
    col_done = '1;
    repeat (4) @(negedge clk);
    chk("single_done", W'(all_done), W'(1));
    chk("single_valid", W'(mv_valid), '0);
    // round robin across 0, 1, 7 with wrap
    do_reset();
    load(0, wa ^ W'(1)); load(1, wa ^ W'(2)); load(7, wa ^ W'(3)); commit();
    load(0, wb ^ W'(1)); load(1, wb ^ W'(2)); load(7, wb ^ W'(3)); commit();
    foreach (exp_gnt[i]) ;
    exp_gnt = '{0, 1, 7, 0, 1, 7};
    exp_word = '{wa ^ W'(1), wa ^ W'(2), wa ^ W'(3), wb ^ W'(1), wb ^ W'(2), wb ^ W'(3)};
    drain(100);
    @(negedge clk);
    chk("rr_count", W'(mv_count), W'(6));
    // backpressure holds the word and blocks further reads
    do_reset();
    mv_ready = 1'b0;
    load(2, wx); load(5, wy); commit();
    exp_gnt = '{2, 5};
    exp_word = '{wx, wy};
    for (int i = 0; i < 20 && !mv_valid; i++) @(negedge clk);
    chk("bp_valid", W'(mv_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", mv_data, wx);
      chk("bp_rden", W'(col_rden), '0);
      chk("bp_count", W'(mv_count), '0);
    end
    @(posedge clk);
    #1 mv_ready = 1'b1;
    drain(50);
    @(negedge clk);
    chk("bp_count_after", W'(mv_count), W'(2));
    // reset during capture discards the popped word
    load(4, wz); exp_gnt.push_back(4); commit();
    for (int i = 0; i < 10 && col_rden == '0; i++) @(negedge clk);
    chk("mid_rden", W'(col_rden), W'(8'h10));
    @(posedge clk);
    #1 reset = 1'b1;
    chk("mid_in_capt", W'(u_dut.r_state), W'(CAPT));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_valid", W'(mv_valid), '0);
    chk("mid_count", W'(mv_count), '0);
    chk("mid_state", W'(u_dut.r_state), W'(SCAN));
    chk("mid_ptr", W'(u_dut.r_ptr), '0);
    repeat (10) @(negedge clk);
    chk("mid_no_word", W'(mv_valid), '0);
    chk("mid_count2", W'(mv_count), '0);
    // saturation: 20 words through a 4-bit counter twin
    do_reset();
    for (int i = 0; i < 20; i++) begin
      load(6, {5{32'h5EED_0000 + 32'(i)}});
      exp_gnt.push_back(6);
      exp_word.push_back({5{32'h5EED_0000 + 32'(i)}});
      commit();
    end
    drain(200);
    @(negedge clk);
    chk("sat_count", W'(s_count), W'(15));
    chk("full_count", W'(mv_count), W'(20));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
